// File: rtl/ascon_pkg.sv
// Shared constants, FSM encodings and elaboration helpers for the masked Ascon
// serial front-end.
package ascon_pkg;

  localparam int ASCON_NONCE_W = 128;
  localparam int ASCON_TAG_W   = 128;

  typedef enum logic {
    LD_LOAD = 1'b0,
    LD_FULL = 1'b1
  } ld_state_e;

  typedef enum logic {
    SO_IDLE  = 1'b0,
    SO_SHIFT = 1'b1
  } so_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascon_shift_reg.sv
// Left-shift register with parallel load; exposes only its top OUT_W bits so
// MSB-first fields stay aligned when the last beat carries padding.
module ascon_shift_reg #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic [STEP-1:0]  shift_in,
  output logic [OUT_W-1:0] q_top
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shifted;

  if (STEP < WIDTH) begin : g_shift
    assign shifted = {q_q[WIDTH-STEP-1:0], shift_in};
  end else begin : g_replace
    assign shifted = shift_in[WIDTH-1:0];
  end

  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_top = q_q[WIDTH-1 -: OUT_W];

endmodule

// File: rtl/ascon_share_serdes.sv
// Serial front-end for the masked Ascon core: deserialises share-split inputs
// into parallel registers and streams ciphertext/tag back out under valid/ready.
module ascon_share_serdes
  import ascon_pkg::*;
#(
  parameter int K      = 128,
  parameter int L      = 40,
  parameter int Y      = 40,
  parameter int W      = 1,
  parameter int SHARES = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SHARES*W-1:0]                   key_si,
  input  logic [SHARES*W-1:0]                   nonce_si,
  input  logic [SHARES*W-1:0]                   ad_si,
  input  logic [SHARES*W-1:0]                   pt_si,
  output logic [SHARES*K-1:0]                   key_o,
  output logic [SHARES*ASCON_NONCE_W-1:0]       nonce_o,
  output logic [SHARES*((L > 0) ? L : 1)-1:0]   ad_o,
  output logic [SHARES*((Y > 0) ? Y : 1)-1:0]   pt_o,
  output logic                                  fields_valid,
  output logic                                  load_done,
  input  logic                                  clear_i,
  input  logic [((Y > 0) ? Y : 1)-1:0]          ct_i,
  input  logic [ASCON_TAG_W-1:0]                tag_i,
  input  logic                                  out_load,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [W-1:0]                          ct_so,
  output logic [W-1:0]                          tag_so,
  output logic                                  out_last
);

  localparam int LW = (L > 0) ? L : 1;
  localparam int YW = (Y > 0) ? Y : 1;
  localparam int NI = ceil_div(max2(max2(K, ASCON_NONCE_W), max2(L, Y)), W);
  localparam int NO = ceil_div(max2(Y, ASCON_TAG_W), W);
  localparam int CW = $clog2(max2(NI, NO) + 1);
  localparam int KB = ceil_div(K, W);
  localparam int NB = ceil_div(ASCON_NONCE_W, W);
  localparam int LB = ceil_div(L, W);
  localparam int YB = ceil_div(Y, W);
  localparam int OW = NO * W;

  localparam logic [CW-1:0] NI_LAST = CW'(NI - 1);
  localparam logic [CW-1:0] NO_LAST = CW'(NO - 1);
  localparam logic [CW-1:0] KB_C    = CW'(KB);
  localparam logic [CW-1:0] NB_C    = CW'(NB);
  localparam logic [CW-1:0] LB_C    = CW'(LB);
  localparam logic [CW-1:0] YB_C    = CW'(YB);

  ld_state_e       ld_state_q, ld_state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic            load_done_q, load_done_d;
  logic            in_fire;

  assign in_fire = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_q  <= LD_LOAD;
      in_cnt_q    <= '0;
      load_done_q <= 1'b0;
    end else begin
      ld_state_q  <= ld_state_d;
      in_cnt_q    <= in_cnt_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    ld_state_d  = ld_state_q;
    in_cnt_d    = in_cnt_q;
    load_done_d = 1'b0;
    case (ld_state_q)
      LD_LOAD: begin
        if (in_fire) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == NI_LAST) begin
            ld_state_d  = LD_FULL;
            load_done_d = 1'b1;
          end
        end
      end
      LD_FULL: begin
        if (clear_i) begin
          ld_state_d = LD_LOAD;
          in_cnt_d   = '0;
        end
      end
      default: ld_state_d = LD_LOAD;
    endcase
  end

  always_comb begin
    in_ready     = (ld_state_q == LD_LOAD);
    fields_valid = (ld_state_q == LD_FULL);
    load_done    = load_done_q;
  end

  // Each field stops shifting once its own beats are in, so shorter fields keep
  // their MSB-first alignment while longer ones finish loading.
  for (genvar s = 0; s < SHARES; s++) begin : g_share
    ascon_shift_reg #(.WIDTH(KB * W), .STEP(W), .OUT_W(K)) u_key (
      .clk, .rst, .load_en(1'b0), .load_val('0),
      .shift_en(in_fire && (in_cnt_q < KB_C)),
      .shift_in(key_si[s*W +: W]), .q_top(key_o[s*K +: K])
    );
    ascon_shift_reg #(.WIDTH(NB * W), .STEP(W), .OUT_W(ASCON_NONCE_W)) u_nonce (
      .clk, .rst, .load_en(1'b0), .load_val('0),
      .shift_en(in_fire && (in_cnt_q < NB_C)),
      .shift_in(nonce_si[s*W +: W]), .q_top(nonce_o[s*ASCON_NONCE_W +: ASCON_NONCE_W])
    );
    if (L > 0) begin : g_ad
      ascon_shift_reg #(.WIDTH(LB * W), .STEP(W), .OUT_W(L)) u_ad (
        .clk, .rst, .load_en(1'b0), .load_val('0),
        .shift_en(in_fire && (in_cnt_q < LB_C)),
        .shift_in(ad_si[s*W +: W]), .q_top(ad_o[s*LW +: LW])
      );
    end else begin : g_no_ad
      assign ad_o[s*LW +: LW] = '0;
    end
    if (Y > 0) begin : g_pt
      ascon_shift_reg #(.WIDTH(YB * W), .STEP(W), .OUT_W(Y)) u_pt (
        .clk, .rst, .load_en(1'b0), .load_val('0),
        .shift_en(in_fire && (in_cnt_q < YB_C)),
        .shift_in(pt_si[s*W +: W]), .q_top(pt_o[s*YW +: YW])
      );
    end else begin : g_no_pt
      assign pt_o[s*YW +: YW] = '0;
    end
  end

  so_state_e       so_state_q, so_state_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            so_load, out_fire;
  logic [OW-1:0]   ct_load, tag_load;

  assign so_load  = (so_state_q == SO_IDLE) && out_load;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      so_state_q <= SO_IDLE;
      out_cnt_q  <= '0;
    end else begin
      so_state_q <= so_state_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  always_comb begin
    so_state_d = so_state_q;
    out_cnt_d  = out_cnt_q;
    case (so_state_q)
      SO_IDLE: begin
        if (out_load) begin
          so_state_d = SO_SHIFT;
          out_cnt_d  = '0;
        end
      end
      SO_SHIFT: begin
        if (out_ready) begin
          if (out_cnt_q == NO_LAST) begin
            so_state_d = SO_IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: so_state_d = SO_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (so_state_q == SO_SHIFT);
    out_last  = (so_state_q == SO_SHIFT) && (out_cnt_q == NO_LAST);
  end

  // Left-align ct/tag so the register shifts zeros into the padding beats.
  if (Y > 0) begin : g_ct_load
    always_comb begin
      ct_load = '0;
      ct_load[OW-1 -: Y] = ct_i;
    end
  end else begin : g_ct_zero
    assign ct_load = '0;
  end

  always_comb begin
    tag_load = '0;
    tag_load[OW-1 -: ASCON_TAG_W] = tag_i;
  end

  ascon_shift_reg #(.WIDTH(OW), .STEP(W), .OUT_W(W)) u_ct (
    .clk, .rst, .load_en(so_load), .load_val(ct_load),
    .shift_en(out_fire), .shift_in('0), .q_top(ct_so)
  );

  ascon_shift_reg #(.WIDTH(OW), .STEP(W), .OUT_W(W)) u_tag (
    .clk, .rst, .load_en(so_load), .load_val(tag_load),
    .shift_en(out_fire), .shift_in('0), .q_top(tag_so)
  );

endmodule

// File: tb/tb_ascon_share_serdes.sv
// Directed bench: W=1/3-share load and output stream on one instance, W=8/L=0
// load, clear and reload on a second instance.
module tb_ascon_share_serdes;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         in_valid, in_ready, fields_valid, load_done, clear_i;
  logic [2:0]   key_si, nonce_si, ad_si, pt_si;
  logic [383:0] key_o, nonce_o;
  logic [119:0] ad_o, pt_o;
  logic [39:0]  ct_i;
  logic [127:0] tag_i;
  logic         out_load, out_valid, out_ready, out_last;
  logic [0:0]   ct_so, tag_so;

  logic         in2_valid, in2_ready, fields2_valid, load_done2, clear2;
  logic [15:0]  key2_si, nonce2_si, ad2_si, pt2_si;
  logic [255:0] key2_o, nonce2_o;
  logic [1:0]   ad2_o;
  logic [79:0]  pt2_o;
  logic         out2_valid, out2_last;
  logic [7:0]   ct2_so, tag2_so;

  ascon_share_serdes #(.K(128), .L(40), .Y(40), .W(1), .SHARES(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_si(key_si), .nonce_si(nonce_si), .ad_si(ad_si), .pt_si(pt_si),
    .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o), .pt_o(pt_o),
    .fields_valid(fields_valid), .load_done(load_done), .clear_i(clear_i),
    .ct_i(ct_i), .tag_i(tag_i), .out_load(out_load), .out_valid(out_valid),
    .out_ready(out_ready), .ct_so(ct_so), .tag_so(tag_so), .out_last(out_last)
  );

  ascon_share_serdes #(.K(128), .L(0), .Y(40), .W(8), .SHARES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready),
    .key_si(key2_si), .nonce_si(nonce2_si), .ad_si(ad2_si), .pt_si(pt2_si),
    .key_o(key2_o), .nonce_o(nonce2_o), .ad_o(ad2_o), .pt_o(pt2_o),
    .fields_valid(fields2_valid), .load_done(load_done2), .clear_i(clear2),
    .ct_i(40'h0), .tag_i(128'h0), .out_load(1'b0), .out_valid(out2_valid),
    .out_ready(1'b0), .ct_so(ct2_so), .tag_so(tag2_so), .out_last(out2_last)
  );

  logic [127:0] key_v, nonce_v, r1_v, r2_v, tag_v, key2_v;
  logic [39:0]  ad_v, pt_v, ct_v;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drives beat i: wide=0 targets the W=1 instance, wide=1 the W=8 instance.
  task automatic applyStimulus(input bit wide, input int i);
    if (!wide) begin
      key_si   = {r2_v[127-i], r1_v[127-i], key_v[127-i] ^ r1_v[127-i] ^ r2_v[127-i]};
      nonce_si = {r1_v[127-i], r2_v[127-i], nonce_v[127-i] ^ r1_v[127-i] ^ r2_v[127-i]};
      if (i < 40) begin
        ad_si = {r2_v[39-i], r1_v[39-i], ad_v[39-i] ^ r1_v[39-i] ^ r2_v[39-i]};
        pt_si = {r1_v[39-i], r2_v[39-i], pt_v[39-i] ^ r1_v[39-i] ^ r2_v[39-i]};
      end else begin
        ad_si = 3'($urandom);
        pt_si = 3'($urandom);
      end
    end else begin
      key2_si   = {r1_v[127-8*i -: 8], key2_v[127-8*i -: 8] ^ r1_v[127-8*i -: 8]};
      nonce2_si = {r2_v[127-8*i -: 8], nonce_v[127-8*i -: 8] ^ r2_v[127-8*i -: 8]};
      ad2_si    = 16'($urandom);
      if (i < 5) pt2_si = {r1_v[39-8*i -: 8], pt_v[39-8*i -: 8] ^ r1_v[39-8*i -: 8]};
      else       pt2_si = 16'($urandom);
    end
  endtask

  int beats, lastCnt, lastIdx, doneCnt, doneAt, accepted, capViol;
  bit stalled, fire;
  logic [127:0] recvCt, recvTag;
  logic [255:0] prevKey;
  logic [79:0]  ptSnap;
  logic         snapCt, snapTag, snapLast;

  initial begin
    key_v   = 128'h7540e9d968c534f3347c799342ed1264;
    nonce_v = 128'h3f0a465dfb478805be644a2627f7c7e8;
    ad_v    = 40'h4153434f4e;
    pt_v    = 40'h6173636f6e;
    ct_v    = 40'h0123456789;
    tag_v   = {16{8'hA5}};
    r1_v    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    r2_v    = 128'h243f6a8885a308d313198a2e03707344;
    key2_v  = key_v;

    rst = 1'b1; in_valid = 0; clear_i = 0; out_load = 0; out_ready = 0;
    ct_i = ct_v; tag_i = tag_v; key_si = 0; nonce_si = 0; ad_si = 0; pt_si = 0;
    in2_valid = 0; clear2 = 0; key2_si = 0; nonce2_si = 0; ad2_si = 0; pt2_si = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_fields_valid", fields_valid, 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_bits", {ct_so, tag_so, out_last}, 0);
    checkOutput("rst_key_zero", key_o[127:0] | key_o[255:128] | key_o[383:256], 0);

    // Partial load interrupted by an asynchronous reset after 60 beats.
    in_valid = 1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, i);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_fields_valid", fields_valid, 0);
    checkOutput("midrst_key_zero", key_o[127:0] | key_o[255:128] | key_o[383:256], 0);
    #2 rst = 1'b0;

    doneCnt = 0; doneAt = -1;
    for (int i = 0; i < 128; i++) begin
      applyStimulus(0, i);
      @(posedge clk); #1;
      if (load_done) begin doneCnt++; doneAt = i; end
    end
    in_valid = 0;
    @(posedge clk); #1;
    if (load_done) doneCnt++;
    checkOutput("load_done_count", doneCnt, 1);
    checkOutput("load_done_beat", doneAt, 127);
    checkOutput("full_fields_valid", fields_valid, 1);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("key_xor", key_o[127:0] ^ key_o[255:128] ^ key_o[383:256], key_v);
    checkOutput("nonce_xor", nonce_o[127:0] ^ nonce_o[255:128] ^ nonce_o[383:256], nonce_v);
    checkOutput("ad_xor", ad_o[39:0] ^ ad_o[79:40] ^ ad_o[119:80], ad_v);
    checkOutput("pt_xor", pt_o[39:0] ^ pt_o[79:40] ^ pt_o[119:80], pt_v);

    // Output stream with a 5-cycle stall at beat 50 and a stray out_load at beat 70.
    out_ready = 1; out_load = 1;
    @(posedge clk); #1;
    out_load = 0;
    checkOutput("stream_start_valid", out_valid, 1);
    beats = 0; lastCnt = 0; lastIdx = -1; stalled = 0; recvCt = '0; recvTag = '0;
    for (int cyc = 0; cyc < 400 && beats < 128; cyc++) begin
      if (beats == 50 && !stalled) begin
        stalled = 1; snapCt = ct_so; snapTag = tag_so; snapLast = out_last;
        out_ready = 0;
        repeat (5) begin
          @(posedge clk); #1;
          checkOutput("stall_hold", {out_valid, ct_so, tag_so, out_last}, {1'b1, snapCt, snapTag, snapLast});
        end
        out_ready = 1;
      end
      out_load = (beats == 70);
      ct_i = (beats == 70) ? 40'hFFFFFFFFFF : ct_v;
      if (out_valid) begin
        recvCt[127-beats]  = ct_so;
        recvTag[127-beats] = tag_so;
        if (out_last) begin lastCnt++; lastIdx = beats; end
        beats++;
      end
      @(posedge clk); #1;
    end
    out_load = 0; ct_i = ct_v;
    checkOutput("stream_beats", beats, 128);
    checkOutput("stream_ct", recvCt, {ct_v, 88'h0});
    checkOutput("stream_tag", recvTag, tag_v);
    checkOutput("out_last_count", lastCnt, 1);
    checkOutput("out_last_beat", lastIdx, 127);
    checkOutput("stream_end_idle", {out_valid, ct_so, tag_so, out_last}, 0);

    // W=8, L=0 instance with random in_valid gaps.
    accepted = 0; capViol = 0; doneCnt = 0; ptSnap = '0;
    for (int cyc = 0; cyc < 300 && !fields2_valid; cyc++) begin
      in2_valid = 1'($urandom_range(0, 1));
      applyStimulus(1, accepted);
      prevKey = key2_o;
      fire = in2_valid && in2_ready;
      @(posedge clk); #1;
      if (fire) accepted++;
      else if (key2_o !== prevKey) capViol++;
      if (load_done2) doneCnt++;
      if (fire && accepted == 5) ptSnap = pt2_o;
    end
    in2_valid = 0;
    checkOutput("w8_accepted", accepted, 16);
    checkOutput("w8_load_done_count", doneCnt, 1);
    checkOutput("w8_no_capture_idle", capViol, 0);
    checkOutput("w8_pt_frozen", pt2_o, ptSnap);
    checkOutput("w8_key_xor", key2_o[127:0] ^ key2_o[255:128], key_v);
    checkOutput("w8_nonce_xor", nonce2_o[127:0] ^ nonce2_o[255:128], nonce_v);
    checkOutput("w8_pt_xor", pt2_o[39:0] ^ pt2_o[79:40], pt_v);
    checkOutput("w8_ad_zero", ad2_o, 0);

    // Clear, then reload with an inverted key; a clear_i during LOAD must be ignored.
    clear2 = 1;
    @(posedge clk); #1;
    clear2 = 0;
    checkOutput("clr_fields_valid", fields2_valid, 0);
    checkOutput("clr_in_ready", in2_ready, 1);
    key2_v = ~key_v; in2_valid = 1; doneCnt = 0; doneAt = -1;
    for (int e = 1; e <= 40 && doneCnt == 0; e++) begin
      applyStimulus(1, e - 1);
      clear2 = (e == 8);
      @(posedge clk); #1;
      if (load_done2) begin doneCnt++; doneAt = e; end
    end
    clear2 = 0; in2_valid = 0;
    checkOutput("reload_done_beats", doneAt, 16);
    checkOutput("reload_key_xor", key2_o[127:0] ^ key2_o[255:128], ~key_v);
    checkOutput("reload_ad_zero", ad2_o, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ascon_share_serdes.md
Name: ascon_share_serdes

Overview:
- Parametrised serial I/O front-end for the masked Ascon core.
- Deserialises the share-split key, nonce, associated-data and plaintext streams, W bits per beat per share, into parallel share registers for the core.
- Serialises the core's recombined ciphertext and tag back out W bits per beat under a valid/ready handshake.
- Replaces fixed 1-bit, fixed-length serial loading with configurable lane width, share count and field lengths, plus flow control and completion flags.

Parameters:
- K, 128, key length in bits (128 or 160).
- L, 40, associated-data length in bits; 0 is allowed.
- Y, 40, plaintext/ciphertext length in bits; 0 is allowed.
- W, 1, bits per beat per share; 1..64.
- SHARES, 3, number of Boolean shares per input bit; 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  loader accepts a beat.
- key_si  in  SHARES*W  key beat; share s occupies bits [s*W +: W].
- nonce_si  in  SHARES*W  nonce beat.
- ad_si  in  SHARES*W  AD beat.
- pt_si  in  SHARES*W  PT beat.
- key_o  out  SHARES*K  shared key; share s at [s*K +: K].
- nonce_o  out  SHARES*128  shared nonce.
- ad_o  out  SHARES*max(L,1)  shared AD.
- pt_o  out  SHARES*max(Y,1)  shared PT.
- fields_valid  out  1  all fields loaded (level).
- load_done  out  1  one-cycle pulse when the last input beat is accepted.
- clear_i  in  1  core has consumed fields; re-arm loader.
- ct_i  in  max(Y,1)  ciphertext from core.
- tag_i  in  128  tag from core.
- out_load  in  1  capture ct_i/tag_i and start streaming.
- out_valid  out  1  output beat present.
- out_ready  in  1  sink accepts a beat.
- ct_so  out  W  ciphertext beat.
- tag_so  out  W  tag beat.
- out_last  out  1  final output beat.

Behaviour:
- Shared constants:
  - NI = ceil(max(K,128,L,Y)/W) input beats.
  - NO = ceil(max(Y,128)/W) output beats.
- Bit order:
  - Every field is MSB first.
  - Beat i, lane j (j=W-1 is the MSB of the beat) carries field bit F-1-(i*W+(W-1-j)).
  - Positions at or below bit index -1 are padding: ignored on input, driven 0 on output.
- Fields are loaded in parallel. A field shorter than NI*W stops capturing once complete. L=0 means ad_si is ignored and ad_o=0; Y=0 is handled the same way for pt and ct.
- Input FSM states LOAD and FULL:
  - Reset: LOAD, beat count 0, all field registers 0, fields_valid=0, load_done=0, in_ready=1.
  - LOAD: in_ready=1. A beat transfers when in_valid&in_ready and shifts each share register left by W. On acceptance of beat NI-1, go to FULL with fields_valid=1 and load_done=1 for that cycle only.
  - FULL: in_ready=0; registers hold. clear_i: go to LOAD, count 0, fields_valid=0; field registers keep their values until overwritten.
  - clear_i in LOAD is ignored.
- Output FSM states IDLE and SHIFT:
  - Reset: IDLE, out_valid=0, out_last=0, ct_so=0, tag_so=0.
  - IDLE with out_load: next cycle enter SHIFT with ct_i/tag_i captured and beat 0 presented. out_valid is high throughout SHIFT.
  - SHIFT: a beat transfers on out_valid&out_ready; then the shift registers advance by W and the count increments. Outputs are held stable while out_ready=0.
  - out_last=1 exactly while beat NO-1 is presented. Its transfer returns the FSM to IDLE with out_valid=0.
  - out_load in SHIFT is ignored.
- Input and output FSMs are independent; both may be active in the same cycle.
- Reset asserted mid-operation returns both FSMs to their reset state immediately.
- Counter width: clog2(max(NI,NO)+1). No wrap-around: counters stop at the terminal beat.

Decomposition:
- Shared package ascon_pkg:
  - ASCON_NONCE_W=128 and ASCON_TAG_W=128.
  - Helper function ceil_div.
  - FSM state encodings LD_LOAD/LD_FULL and SO_IDLE/SO_SHIFT.
- One sub-module, ascon_shift_reg: a parametric width/step left-shift register with load and shift enables. It is instantiated per share per field and for ct/tag.

Test Plan:
- Load, W=1, SHARES=3, K=128, L=Y=40:
  - Stimulus: key 7540e9d968c534f3347c799342ed1264, nonce 3f0a465dfb478805be644a2627f7c7e8, AD 4153434f4e, PT 6173636f6e, with share0=value^r1^r2, share1=r1, share2=r2.
  - Required: XOR of the shares of each output field equals its value; load_done pulses once, 128 cycles after the first beat.
- W=8, in_valid toggled randomly:
  - NI=16 accepted beats.
  - AD/PT registers unchanged after beat 4.
  - No capture on cycles with in_valid=0.
- Output stream, W=1:
  - Stimulus: ct_i=40'h0123456789, tag_i=128'hA5..A5, out_ready held 1.
  - Required: 128 beats; ct_so reproduces ct MSB first then 0s; tag_so reproduces tag; out_last on beat 127 only.
- Backpressure on output: out_ready low for 5 cycles mid-stream → ct_so/tag_so/out_last held; no beat lost or duplicated.
- out_load pulsed during SHIFT → ignored; stream continues with the original capture.
- Reset mid-load at beat 60 → fields_valid=0, in_ready=1; a fresh full load completes correctly.
- L=0, clear_i, then reload → ad_o=0 throughout; second load_done occurs exactly NI beats after clear_i.
